// File: rtl/sccb_arb_pkg.sv
// Shared constants for the dual-requester SCCB arbiter: field widths, FSM state codes, grant codes.
package sccb_arb_pkg;

    localparam int unsigned CMD_W = 16;
    localparam int unsigned ID_W  = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_WAIT = 2'd2;
    localparam state_t ST_GAP  = 2'd3;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

endpackage

// File: rtl/sccb_dual_arbiter_if.sv
// Requester and sender handshake bundle; the arbiter uses the slave view, the environment the master.
interface sccb_dual_arbiter_if;

    logic                           req0;
    logic [sccb_arb_pkg::ID_W-1:0]  id0;
    logic [sccb_arb_pkg::CMD_W-1:0] cmd0;
    logic                           taken0;
    logic                           req1;
    logic [sccb_arb_pkg::ID_W-1:0]  id1;
    logic [sccb_arb_pkg::CMD_W-1:0] cmd1;
    logic                           taken1;
    logic                           snd_send;
    logic [sccb_arb_pkg::ID_W-1:0]  snd_id;
    logic [sccb_arb_pkg::CMD_W-1:0] snd_cmd;
    logic                           snd_taken;

    modport slave (
        input  req0, id0, cmd0, req1, id1, cmd1, snd_taken,
        output taken0, taken1, snd_send, snd_id, snd_cmd
    );

    modport master (
        output req0, id0, cmd0, req1, id1, cmd1, snd_taken,
        input  taken0, taken1, snd_send, snd_id, snd_cmd
    );

endinterface

// File: rtl/sccb_arb_rr.sv
// Two-request round-robin picker: combinational one-hot pick, registered last-served pointer.
module sccb_arb_rr
    import sccb_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_served,
    output logic [1:0] o_pick
);

    logic r_last;

    always_comb begin
        o_pick = GRANT_NONE;
        if (i_req == 2'b11) begin
            o_pick = r_last ? GRANT_0 : GRANT_1;
        end else begin
            o_pick = i_req;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_update) begin
            r_last <= i_served;
        end
    end

endmodule

// File: rtl/sccb_dual_arbiter.sv
// Shares one SCCB sender between two register sequencers with round-robin, idle gap and watchdog.
// Optional per-requester statistics are enabled by defining SCCB_ARB_STATS_EN.
module sccb_dual_arbiter
    import sccb_arb_pkg::*;
#(
    parameter logic [15:0] GAP_CYCLES     = 16'd200,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    sccb_dual_arbiter_if.slave   bus,
    output logic [1:0]           o_grant,
    output logic                 o_busy,
    output logic                 o_timeout_err,
    input  logic                 i_clear_err
`ifdef SCCB_ARB_STATS_EN
    ,
    output logic [15:0]          o_cnt0,
    output logic [15:0]          o_cnt1,
    output logic [7:0]           o_timeout_cnt
`endif
);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_send;
    logic [ID_W-1:0]  r_id;
    logic [CMD_W-1:0] r_cmd;
    logic [1:0]       r_taken;
    logic             r_err;
    logic [23:0]      r_wd;
    logic [15:0]      r_gap;

    logic [1:0] w_pick;
    logic       w_accept;
    logic       w_expire;

    assign w_accept = (r_state == ST_WAIT) && bus.snd_taken;
    assign w_expire = (r_state == ST_WAIT) && !bus.snd_taken
                      && (r_wd == TIMEOUT_CYCLES - 24'd1);

    sccb_arb_rr u_rr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    ({bus.req1, bus.req0}),
        .i_update (w_accept || w_expire),
        .i_served (r_grant[1]),
        .o_pick   (w_pick)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= GRANT_NONE;
            r_send  <= 1'b0;
            r_id    <= '0;
            r_cmd   <= '0;
            r_taken <= 2'b00;
            r_wd    <= '0;
            r_gap   <= '0;
        end else begin
            r_taken <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick != GRANT_NONE) begin
                        r_grant <= w_pick;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_id    <= r_grant[1] ? bus.id1 : bus.id0;
                    r_cmd   <= r_grant[1] ? bus.cmd1 : bus.cmd0;
                    r_send  <= 1'b1;
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_accept || w_expire) begin
                        r_taken <= w_accept ? r_grant : 2'b00;
                        r_send  <= 1'b0;
                        r_grant <= GRANT_NONE;
                        r_gap   <= GAP_CYCLES;
                        r_state <= ST_GAP;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + 24'd1;
                    end
                end
                ST_GAP: begin
                    if (r_gap <= 16'd1) begin
                        r_gap   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A timeout in the same cycle as clear_err leaves the flag set.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end else if (i_clear_err) begin
            r_err <= 1'b0;
        end
    end

`ifdef SCCB_ARB_STATS_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;
    logic [7:0]  r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt0   <= '0;
            r_cnt1   <= '0;
            r_to_cnt <= '0;
        end else begin
            if (i_clear_err) begin
                r_cnt0 <= '0;
                r_cnt1 <= '0;
            end else if (w_accept) begin
                if (r_grant[0] && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 16'd1;
                if (r_grant[1] && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 16'd1;
            end
            if (w_expire && (r_to_cnt != '1)) begin
                r_to_cnt <= r_to_cnt + 8'd1;
            end
        end
    end

    assign o_cnt0        = r_cnt0;
    assign o_cnt1        = r_cnt1;
    assign o_timeout_cnt = r_to_cnt;
`endif

    assign bus.snd_send   = r_send;
    assign bus.snd_id     = r_id;
    assign bus.snd_cmd    = r_cmd;
    assign bus.taken0     = r_taken[0];
    assign bus.taken1     = r_taken[1];
    assign o_grant        = r_grant;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_timeout_err  = r_err;

endmodule

// File: tb/tb_sccb_dual_arbiter.sv
// Directed bench for sccb_dual_arbiter: cycle-vector table plus hand sequences for long waits.
module tb_sccb_dual_arbiter;
    import sccb_arb_pkg::*;

    localparam logic [15:0] GAP = 16'd5;
    localparam logic [23:0] TMO = 24'd100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_err;
    logic [1:0] grant;
    logic       busy;
    logic       terr;
`ifdef SCCB_ARB_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [7:0]  tcnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int tk0_seen = 0;
    int tk1_seen = 0;

    always #5 clk = ~clk;

    sccb_dual_arbiter_if bus ();

    sccb_dual_arbiter #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .bus           (bus),
        .o_grant       (grant),
        .o_busy        (busy),
        .o_timeout_err (terr),
        .i_clear_err   (clear_err)
`ifdef SCCB_ARB_STATS_EN
        ,
        .o_cnt0        (cnt0),
        .o_cnt1        (cnt1),
        .o_timeout_cnt (tcnt)
`endif
    );

    typedef struct {
        logic        rst_n;
        logic        req0;
        logic        req1;
        logic        snd_taken;
        logic [1:0]  grant;
        logic        send;
        logic [1:0]  taken;
        logic        busy;
        logic [7:0]  id;
        logic [15:0] cmd;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rn, input logic r0, input logic r1, input logic st,
                                input logic [1:0] g, input logic s, input logic [1:0] tk,
                                input logic b, input logic [7:0] id, input logic [15:0] cmd);
        vec_t v;
        v.rst_n = rn; v.req0 = r0; v.req1 = r1; v.snd_taken = st;
        v.grant = g; v.send = s; v.taken = tk; v.busy = b; v.id = id; v.cmd = cmd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.taken0 === 1'b1) tk0_seen++;
        if (bus.taken1 === 1'b1) tk1_seen++;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        check({name, " reached idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global time limit: run did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int          n;
        int          t0;
        int          t1;
        logic [1:0]  exp_g[4];

        rst_n = 1'b0; clear_err = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.snd_taken = 1'b0;
        bus.id0 = 8'h42; bus.cmd0 = 16'h1280;
        bus.id1 = 8'h21; bus.cmd1 = 16'h3456;

        //            rn r0 r1 st  grant  send taken  busy id     cmd
        vecs[0]  = mk(0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 8'h00, 16'h0000);
        vecs[1]  = mk(1, 0, 0, 1, 2'b00, 0, 2'b00, 0, 8'h00, 16'h0000);
        vecs[2]  = mk(1, 1, 0, 0, 2'b01, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[3]  = mk(1, 1, 0, 0, 2'b01, 1, 2'b00, 1, 8'h42, 16'h1280);
        vecs[4]  = mk(1, 1, 0, 0, 2'b01, 1, 2'b00, 1, 8'h42, 16'h1280);
        vecs[5]  = mk(1, 1, 0, 1, 2'b00, 0, 2'b01, 1, 8'h00, 16'h0000);
        vecs[6]  = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[7]  = mk(1, 1, 1, 1, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[8]  = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[9]  = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[10] = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 0, 8'h00, 16'h0000);
        vecs[11] = mk(1, 1, 1, 0, 2'b10, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[12] = mk(1, 1, 1, 0, 2'b10, 1, 2'b00, 1, 8'h21, 16'h3456);
        vecs[13] = mk(1, 1, 1, 1, 2'b00, 0, 2'b10, 1, 8'h00, 16'h0000);
        vecs[14] = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[15] = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[16] = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[17] = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 1, 8'h00, 16'h0000);
        vecs[18] = mk(1, 1, 1, 0, 2'b00, 0, 2'b00, 0, 8'h00, 16'h0000);
        vecs[19] = mk(1, 1, 1, 0, 2'b01, 0, 2'b00, 1, 8'h00, 16'h0000);

        for (int i = 0; i < 20; i++) begin
            rst_n = vecs[i].rst_n;
            bus.req0 = vecs[i].req0;
            bus.req1 = vecs[i].req1;
            bus.snd_taken = vecs[i].snd_taken;
            step();
            check($sformatf("v%0d grant", i), {30'd0, grant}, {30'd0, vecs[i].grant});
            check($sformatf("v%0d send", i), {31'd0, bus.snd_send}, {31'd0, vecs[i].send});
            check($sformatf("v%0d taken", i), {30'd0, bus.taken1, bus.taken0},
                  {30'd0, vecs[i].taken});
            check($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
            check($sformatf("v%0d timeout_err", i), {31'd0, terr}, 32'd0);
            if (vecs[i].send || !vecs[i].rst_n) begin
                check($sformatf("v%0d snd_id", i), {24'd0, bus.snd_id}, {24'd0, vecs[i].id});
                check($sformatf("v%0d snd_cmd", i), {16'd0, bus.snd_cmd}, {16'd0, vecs[i].cmd});
            end
        end
        bus.snd_taken = 1'b0;

        // Requester 0 granted at v19; its command must be frozen across a long WAIT.
        bus.req1 = 1'b0;
        step();
        check("s1 send rises", {31'd0, bus.snd_send}, 32'd1);
        check("s1 snd_id", {24'd0, bus.snd_id}, 32'h42);
        check("s1 snd_cmd", {16'd0, bus.snd_cmd}, 32'h1280);
        bus.cmd0 = 16'h1100;
        bus.id0  = 8'h99;
        t0 = tk0_seen;
        repeat (49) step();
        check("s3 send held", {31'd0, bus.snd_send}, 32'd1);
        check("s3 snd_cmd frozen", {16'd0, bus.snd_cmd}, 32'h1280);
        check("s3 snd_id frozen", {24'd0, bus.snd_id}, 32'h42);
        bus.snd_taken = 1'b1;
        step();
        bus.snd_taken = 1'b0;
        check("s1 taken0 pulse", {31'd0, bus.taken0}, 32'd1);
        check("s1 send drops", {31'd0, bus.snd_send}, 32'd0);
        check("s1 grant cleared", {30'd0, grant}, 32'd0);
        bus.req0 = 1'b0;
        step();
        check("s1 single taken0", tk0_seen - t0, 32'd1);
        bus.cmd0 = 16'h1280;
        bus.id0  = 8'h42;

        // Watchdog: requester 1 is next (0 was last served); clear_err lands on the expiry cycle.
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        wait_idle("s4 pre");
        step();
        check("s4 grant 1", {30'd0, grant}, 32'b10);
        step();
        t0 = tk0_seen;
        t1 = tk1_seen;
        n = 0;
        while (bus.snd_send === 1'b1 && n < 300) begin
            n++;
            if (n == 100) clear_err = 1'b1;
            step();
        end
        clear_err = 1'b0;
        check("s4 send high cycles", n, 32'd100);
        check("s4 timeout_err set wins", {31'd0, terr}, 32'd1);
        check("s4 grant cleared", {30'd0, grant}, 32'd0);
        check("s4 no taken", (tk0_seen - t0) + (tk1_seen - t1), 32'd0);
        wait_idle("s4 gap");
        step();
        check("s4 other served next", {30'd0, grant}, 32'b01);
        step();
        check("s4 next send", {31'd0, bus.snd_send}, 32'd1);
        check("s4 err sticky", {31'd0, terr}, 32'd1);
        bus.snd_taken = 1'b1;
        step();
        bus.snd_taken = 1'b0;
        check("s4 taken0", {31'd0, bus.taken0}, 32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("s4 clear_err", {31'd0, terr}, 32'd0);

        // Reset mid-WAIT aborts silently; requester 0 then wins the first tie.
        bus.req0 = 1'b0;
        wait_idle("s5 pre");
        step();
        step();
        step();
        check("s5 in wait", {31'd0, bus.snd_send}, 32'd1);
        t0 = tk0_seen;
        t1 = tk1_seen;
        rst_n = 1'b0;
        step();
        check("s5 rst grant", {30'd0, grant}, 32'd0);
        check("s5 rst send", {31'd0, bus.snd_send}, 32'd0);
        check("s5 rst busy", {31'd0, busy}, 32'd0);
        check("s5 rst snd_id", {24'd0, bus.snd_id}, 32'd0);
        check("s5 rst snd_cmd", {16'd0, bus.snd_cmd}, 32'd0);
        check("s5 rst no taken", (tk0_seen - t0) + (tk1_seen - t1), 32'd0);
        rst_n = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;

        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        t0 = tk0_seen;
        t1 = tk1_seen;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("s2 grant %0d", k), {30'd0, grant}, {30'd0, exp_g[k]});
            step();
            step();
            bus.snd_taken = 1'b1;
            step();
            bus.snd_taken = 1'b0;
            wait_idle($sformatf("s2 txn %0d", k));
        end
        check("s2 taken0 count", tk0_seen - t0, 32'd2);
        check("s2 taken1 count", tk1_seen - t1, 32'd2);
`ifdef SCCB_ARB_STATS_EN
        check("s6 cnt0", {16'd0, cnt0}, 32'd2);
        check("s6 cnt1", {16'd0, cnt1}, 32'd2);
        check("s6 timeout_cnt", {24'd0, tcnt}, 32'd0);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        check("s6 cnt0 cleared", {16'd0, cnt0}, 32'd0);
        check("s6 cnt1 cleared", {16'd0, cnt1}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sccb_dual_arbiter.md
Name: sccb_dual_arbiter

Overview:
- Shares one SCCB master (i2c_sender) between the left and right OV7670 register sequencers, so both cameras configure over a single sender instance.
- Round-robin arbitration with command hold until the sender accepts it.
- Enforces an inter-transaction idle gap and a watchdog on the sender's accept handshake.
- Sits between both register tables and the sender, inside the stereo camera config path.

Parameters:
GAP_CYCLES, 16'd200, idle clk cycles after each accepted command before re-arbitration (≥1)
TIMEOUT_CYCLES, 24'd2_000_000, max cycles in WAIT before abort (≥2)

Ports:
clk  in  1  system clock, single domain
rst_n  in  1  synchronous active-low reset
req0  in  1  requester 0 (left) has a command pending; level, held until taken0
id0  in  8  requester 0 SCCB device address
cmd0  in  16  requester 0 {register[15:8], value[7:0]}
taken0  out  1  one-cycle pulse: requester 0 command accepted
req1  in  1  requester 1 (right), same rules as req0
id1  in  8  requester 1 device address
cmd1  in  16  requester 1 command
taken1  out  1  one-cycle pulse for requester 1
snd_send  out  1  to sender: command valid
snd_id  out  8  to sender id
snd_cmd  out  16  to sender {reg_xhdl0, value}
snd_taken  in  1  sender accept pulse
grant  out  2  one-hot current owner; 2'b00 when none
busy  out  1  state != IDLE
timeout_err  out  1  sticky watchdog flag
clear_err  in  1  clears timeout_err (1-cycle pulse)

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE, grant=00, snd_send=0, snd_id=0, snd_cmd=0, taken0/1=0, busy=0, timeout_err=0, last-served pointer=1 (so requester 0 wins first tie), counters=0. Mid-transaction reset aborts with no taken pulse.
- FSM states:
  - IDLE:
    - Neither req → stay.
    - Exactly one req → grant it.
    - Both req → grant the one not equal to the last-served pointer.
    - Next cycle → LOAD.
  - LOAD:
    - Register id/cmd of the granted requester into snd_id/snd_cmd.
    - snd_send=1 from the next cycle.
    - → WAIT.
  - WAIT:
    - snd_send held 1; snd_id/snd_cmd frozen, so requester input changes are ignored.
    - On snd_taken=1: pulse takenN=1 for exactly one cycle (the cycle after snd_taken), deassert snd_send that same cycle, update last-served pointer, grant=00, load gap counter → GAP.
    - If the watchdog reaches TIMEOUT_CYCLES-1 without snd_taken: snd_send=0, timeout_err=1, no taken pulse, pointer still toggles → GAP.
  - GAP:
    - Decrement counter to 0 (exactly GAP_CYCLES cycles), then → IDLE.
    - Requests are sampled only in IDLE.
- Latency: req asserted in IDLE → snd_send high 2 cycles later.
- A req dropped while granted is ignored; the transaction completes.
- snd_taken outside WAIT is ignored.
- clear_err and a timeout in the same cycle: set wins.
- Counters saturate, never wrap.
- grant is one-hot or zero at all times.

Optional Feature:
SCCB_ARB_STATS_EN
- Defined:
  - Adds outputs cnt0, cnt1 [15:0]: accepted commands per requester, saturating at 16'hFFFF, reset to 0, cleared by clear_err.
  - Adds output timeout_cnt [7:0], saturating.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package sccb_arb_pkg: state enum (IDLE, LOAD, WAIT, GAP), command width 16, id width 8, grant encodings.
- One sub-module, sccb_arb_rr: two-request round-robin picker with a last-served pointer (combinational pick, registered pointer).
- Mux, watchdog and gap counter stay in the top.

Test Plan:
1. Reset then req0=1, id0=8'h42, cmd0=16'h1280, sender pulses snd_taken 50 cycles after snd_send → snd_cmd=16'h1280, snd_id=8'h42 two cycles after req, one taken0 pulse, grant back to 00, no re-grant for GAP_CYCLES.
2. req0 and req1 held together for 4 transactions → grants alternate 01,10,01,10; taken0/taken1 each pulse twice.
3. cmd0 changed from 16'h1280 to 16'h1100 during WAIT → snd_cmd stays 16'h1280 until taken.
4. Sender never pulses snd_taken (TIMEOUT_CYCLES=100) → snd_send drops after 100 WAIT cycles, timeout_err=1, no taken pulse, other requester served next; clear_err → timeout_err=0.
5. rst_n=0 during WAIT → all outputs at reset values next cycle; after release, requester 0 wins a tie.
6. snd_taken pulsed while in IDLE/GAP → no taken pulse, state unaffected; with SCCB_ARB_STATS_EN, cnt0/cnt1 match accepted counts from scenario 2 (2/2).
